// File: rtl/idac_ctrl_if.sv
// Bus between a DAC code requester and idac_ctrl: target handshake, ramp
// controls, and the registered DAC pin / status outputs.
interface idac_ctrl_if #(
    parameter int PER_W = 16
);
    logic             en_i;
    logic [4:0]       cal_i;
    logic [7:0]       target_i;
    logic             target_valid_i;
    logic             target_ready_o;
    logic             ramp_en_i;
    logic [7:0]       step_i;
    logic [PER_W-1:0] period_i;
    logic             dac_en_o;
    logic             dac_refresh_o;
    logic [4:0]       dac_cal_o;
    logic [7:0]       dac_in_o;
    logic [7:0]       cur_code_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output en_i, cal_i, target_i, target_valid_i, ramp_en_i, step_i, period_i,
        input  target_ready_o, dac_en_o, dac_refresh_o, dac_cal_o, dac_in_o,
               cur_code_o, busy_o, done_o
    );

    modport slave (
        input  en_i, cal_i, target_i, target_valid_i, ramp_en_i, step_i, period_i,
        output target_ready_o, dac_en_o, dac_refresh_o, dac_cal_o, dac_in_o,
               cur_code_o, busy_o, done_o
    );
endinterface

// File: rtl/idac_ctrl.sv
// Current-DAC update controller: latches a target code and walks the DAC
// there through SETUP/PULSE refresh cycles, optionally ramping in steps.
module idac_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int PER_W     = 16
) (
    input logic        clk_i,
    input logic        rst_i,
    idac_ctrl_if.slave bus
);
    typedef enum logic [2:0] {OFF, IDLE, SETUP, PULSE, WAIT} state_t;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);

    state_t           state_r;
    logic [7:0]       target_r;
    logic [7:0]       cnt_r;
    logic [PER_W-1:0] wcnt_r;
    logic [PER_W-1:0] period_r;
    logic             dac_en_r;
    logic             refresh_r;
    logic [4:0]       cal_r;
    logic [7:0]       din_r;
    logic [7:0]       cur_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    logic [7:0] tgt_sel;
    logic [7:0] nxt_code;
    logic       go_setup;

    // One step toward tgt without wrapping; a zero step still makes progress.
    function automatic logic [7:0] next_code(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic ramp, input logic [7:0] step);
        logic [7:0] st;
        logic [7:0] diff;
        st = (step == 8'd0) ? 8'd1 : step;
        if (!ramp || cur == tgt) return tgt;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff <= st) ? tgt : cur + st;
        end
        diff = cur - tgt;
        return (diff <= st) ? tgt : cur - st;
    endfunction

    // A fresh handshake uses the incoming target; ramp continuations use the stored one.
    always_comb begin
        tgt_sel  = (state_r == IDLE) ? bus.target_i : target_r;
        nxt_code = next_code(cur_r, tgt_sel, bus.ramp_en_i, bus.step_i);
        go_setup = 1'b0;
        if (bus.en_i) begin
            case (state_r)
                IDLE:    go_setup = bus.target_valid_i && ready_r;
                PULSE:   go_setup = (cnt_r == 8'd0) && (cur_r != target_r) && (period_r == '0);
                WAIT:    go_setup = (wcnt_r == '0);
                default: go_setup = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= OFF;
            target_r  <= 8'd0;
            cnt_r     <= 8'd0;
            wcnt_r    <= '0;
            period_r  <= '0;
            dac_en_r  <= 1'b0;
            refresh_r <= 1'b0;
            cal_r     <= 5'd0;
            din_r     <= 8'd0;
            cur_r     <= 8'd0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (!bus.en_i) begin
            // Disabling clears the DAC latch, so the mirrored code goes to 0 too.
            state_r   <= OFF;
            target_r  <= 8'd0;
            cnt_r     <= 8'd0;
            wcnt_r    <= '0;
            dac_en_r  <= 1'b0;
            refresh_r <= 1'b0;
            cur_r     <= 8'd0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            if (state_r == OFF || state_r == IDLE) cal_r <= bus.cal_i;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                OFF: begin
                    cal_r    <= bus.cal_i;
                    state_r  <= IDLE;
                    dac_en_r <= 1'b1;
                    ready_r  <= 1'b1;
                end
                IDLE: begin
                    cal_r <= bus.cal_i;
                    if (go_setup) begin
                        target_r <= bus.target_i;
                        ready_r  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_r == 8'd0) begin
                        state_r   <= PULSE;
                        refresh_r <= 1'b1;
                        cur_r     <= din_r;
                        cnt_r     <= PULSE_LD;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt_r != 8'd0) begin
                        cnt_r <= cnt_r - 8'd1;
                    end else begin
                        refresh_r <= 1'b0;
                        if (cur_r == target_r) begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end else if (period_r != '0) begin
                            state_r <= WAIT;
                            wcnt_r  <= period_r - 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt_r != '0) wcnt_r <= wcnt_r - 1'b1;
                end
                default: state_r <= OFF;
            endcase
            // Every path into SETUP samples the ramp controls and presents the new code.
            if (go_setup) begin
                state_r  <= SETUP;
                din_r    <= nxt_code;
                cnt_r    <= SETUP_LD;
                busy_r   <= 1'b1;
                period_r <= bus.period_i;
            end
        end
    end

    assign bus.target_ready_o = ready_r;
    assign bus.dac_en_o       = dac_en_r;
    assign bus.dac_refresh_o  = refresh_r;
    assign bus.dac_cal_o      = cal_r;
    assign bus.dac_in_o       = din_r;
    assign bus.cur_code_o     = cur_r;
    assign bus.busy_o         = busy_r;
    assign bus.done_o         = done_r;
endmodule

// File: tb/tb_idac_ctrl.sv
// Directed bench for idac_ctrl: single update, ramps, disable, cal freeze,
// and asynchronous reset during a refresh pulse.
module tb_idac_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   n;
    int   d0;

    idac_ctrl_if #(.PER_W(16)) ifc ();

    idac_ctrl #(.SETUP_CYC(2), .PULSE_CYC(2), .PER_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ifc.done_o === 1'b1) done_cnt++;
    endtask

    task automatic send(input logic [7:0] tgt, input logic ramp, input logic [7:0] st,
                        input logic [15:0] per);
        ifc.target_i       = tgt;
        ifc.ramp_en_i      = ramp;
        ifc.step_i         = st;
        ifc.period_i       = per;
        ifc.target_valid_i = 1'b1;
        chk("ready_before_send", ifc.target_ready_o, 1);
        tick();
        ifc.target_valid_i = 1'b0;
        chk("busy_after_accept", ifc.busy_o, 1);
    endtask

    // Ticks until a refresh rising edge; n returns the cycles taken.
    task automatic wait_rise(output int cyc);
        logic prev;
        prev = ifc.dac_refresh_o;
        cyc  = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            cyc++;
            if (ifc.dac_refresh_o && !prev) return;
            prev = ifc.dac_refresh_o;
        end
        chk("refresh_timeout", ifc.dac_refresh_o, 1);
    endtask

    // From the first PULSE cycle of the final update: done two edges later.
    task automatic expect_done(input string tag);
        tick();
        tick();
        chk({tag, "_done"}, ifc.done_o, 1);
        chk({tag, "_ready"}, ifc.target_ready_o, 1);
        chk({tag, "_busy"}, ifc.busy_o, 0);
    endtask

    initial begin
        ifc.en_i = 0; ifc.cal_i = 0; ifc.target_i = 0; ifc.target_valid_i = 0;
        ifc.ramp_en_i = 0; ifc.step_i = 0; ifc.period_i = 0;
        #1;
        chk("rst_dac_en", ifc.dac_en_o, 0);
        chk("rst_refresh", ifc.dac_refresh_o, 0);
        chk("rst_din", ifc.dac_in_o, 0);
        chk("rst_cur", ifc.cur_code_o, 0);
        chk("rst_ready", ifc.target_ready_o, 0);
        chk("rst_busy", ifc.busy_o, 0);
        #12 rst = 1'b0;
        tick();
        chk("off_no_en", ifc.dac_en_o, 0);
        ifc.en_i = 1'b1;
        tick();
        chk("idle_dac_en", ifc.dac_en_o, 1);
        chk("idle_ready", ifc.target_ready_o, 1);

        // Single jump to 127
        send(8'd127, 1'b0, 8'd0, 16'd0);
        chk("j_din", ifc.dac_in_o, 127);
        chk("j_ref0", ifc.dac_refresh_o, 0);
        chk("j_ready0", ifc.target_ready_o, 0);
        tick();
        chk("j_setup2_ref", ifc.dac_refresh_o, 0);
        chk("j_setup2_din", ifc.dac_in_o, 127);
        tick();
        chk("j_pulse1_ref", ifc.dac_refresh_o, 1);
        chk("j_pulse1_cur", ifc.cur_code_o, 127);
        tick();
        chk("j_pulse2_ref", ifc.dac_refresh_o, 1);
        chk("j_pulse2_din", ifc.dac_in_o, 127);
        tick();
        chk("j_done", ifc.done_o, 1);
        chk("j_ref_low", ifc.dac_refresh_o, 0);
        chk("j_ready", ifc.target_ready_o, 1);
        tick();
        chk("j_done_once", ifc.done_o, 0);
        chk("j_din_hold", ifc.dac_in_o, 127);

        // Disable/enable to clear the code, then ramp 0 -> 10 step 4 period 3
        ifc.en_i = 1'b0;
        tick();
        chk("dis_cur", ifc.cur_code_o, 0);
        ifc.en_i = 1'b1;
        tick();
        d0 = done_cnt;
        send(8'd10, 1'b1, 8'd4, 16'd3);
        chk("r_din1", ifc.dac_in_o, 4);
        wait_rise(n);
        chk("r_lat1", n, 2);
        chk("r_code1", ifc.cur_code_o, 4);
        wait_rise(n);
        chk("r_gap2", n, 7);
        chk("r_code2", ifc.cur_code_o, 8);
        wait_rise(n);
        chk("r_gap3", n, 7);
        chk("r_code3", ifc.cur_code_o, 10);
        expect_done("r");
        tick();
        chk("r_single_done", done_cnt - d0, 1);

        // Ramp down 200 -> 198 with step 5: one clamped update
        send(8'd200, 1'b0, 8'd0, 16'd0);
        wait_rise(n);
        expect_done("set200");
        d0 = done_cnt;
        send(8'd198, 1'b1, 8'd5, 16'd0);
        wait_rise(n);
        chk("dn_code", ifc.cur_code_o, 198);
        expect_done("dn");
        tick();
        chk("dn_single", done_cnt - d0, 1);

        // Zero step treated as one: 5 -> 6 -> 7, period 0 gap = 4
        send(8'd5, 1'b0, 8'd0, 16'd0);
        wait_rise(n);
        expect_done("set5");
        send(8'd7, 1'b1, 8'd0, 16'd0);
        wait_rise(n);
        chk("z_code1", ifc.cur_code_o, 6);
        wait_rise(n);
        chk("z_gap", n, 4);
        chk("z_code2", ifc.cur_code_o, 7);
        expect_done("z");

        // Target equal to current code still refreshes once
        send(8'd7, 1'b0, 8'd0, 16'd0);
        wait_rise(n);
        chk("eq_lat", n, 2);
        chk("eq_code", ifc.cur_code_o, 7);
        expect_done("eq");

        // Disable in WAIT
        send(8'd20, 1'b1, 8'd4, 16'd5);
        wait_rise(n);
        chk("w_code", ifc.cur_code_o, 11);
        tick(); tick(); tick();
        chk("w_in_wait_busy", ifc.busy_o, 1);
        chk("w_in_wait_ref", ifc.dac_refresh_o, 0);
        d0 = done_cnt;
        ifc.en_i = 1'b0;
        tick();
        chk("w_dac_en", ifc.dac_en_o, 0);
        chk("w_cur", ifc.cur_code_o, 0);
        chk("w_busy", ifc.busy_o, 0);
        chk("w_done", ifc.done_o, 0);
        ifc.en_i = 1'b1;
        tick();
        chk("w_reen_ready", ifc.target_ready_o, 1);
        chk("w_reen_en", ifc.dac_en_o, 1);
        repeat (10) tick();
        chk("w_no_resume", ifc.busy_o, 0);
        chk("w_no_done", done_cnt - d0, 0);

        // Calibration frozen during an update
        ifc.cal_i = 5'd3;
        tick();
        chk("cal_follow", ifc.dac_cal_o, 3);
        send(8'd50, 1'b0, 8'd0, 16'd0);
        ifc.cal_i = 5'd20;
        tick();
        chk("cal_frz_setup", ifc.dac_cal_o, 3);
        tick();
        chk("cal_frz_pulse", ifc.dac_cal_o, 3);
        tick();
        tick();
        chk("cal_done", ifc.done_o, 1);
        chk("cal_at_idle", ifc.dac_cal_o, 3);
        tick();
        chk("cal_updated", ifc.dac_cal_o, 20);

        // Asynchronous reset during PULSE
        send(8'd60, 1'b0, 8'd0, 16'd0);
        tick();
        tick();
        chk("ar_in_pulse", ifc.dac_refresh_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ref", ifc.dac_refresh_o, 0);
        chk("ar_en", ifc.dac_en_o, 0);
        chk("ar_cur", ifc.cur_code_o, 0);
        chk("ar_din", ifc.dac_in_o, 0);
        chk("ar_cal", ifc.dac_cal_o, 0);
        chk("ar_busy", ifc.busy_o, 0);
        chk("ar_ready", ifc.target_ready_o, 0);
        #2 rst = 1'b0;
        tick();
        chk("ar_reen_en", ifc.dac_en_o, 1);
        chk("ar_reen_ready", ifc.target_ready_o, 1);
        chk("ar_reen_cur", ifc.cur_code_o, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
